vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Timing decoder that sits directly downstream of the pixel-clock horizontal/vertical counters (horizontal 0..823, vertical 0..600).
- Converts raw counter values into registered hsync, vsync, data-enable, active-area pixel coordinates and a start-of-frame pulse.
- Runs one phase FSM per axis and checks that incoming counts follow a legal sequence, so a stalled or glitched counter is flagged and does not corrupt the sync outputs.
- Runs in the pixel-clock domain.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch length in counts
- H_SYNC, 96, hsync pulse width in counts
- H_TOTAL, 824, counts per line; back porch = H_TOTAL-H_ACTIVE-H_FP-H_SYNC (72)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vsync width in lines
- V_TOTAL, 601, lines per frame; back porch = remainder (109)
- HS_POL, 0, asserted level of hsync (0 = active-low)
- VS_POL, 0, asserted level of vsync

Ports:
- clk  input  1  pixel clock
- rst  input  1  asynchronous active-high reset
- cen  input  1  clock enable; all state holds when low
- h_val  input  10  horizontal counter value
- v_val  input  10  vertical counter value
- hsync  output  1  horizontal sync, polarity HS_POL
- vsync  output  1  vertical sync, polarity VS_POL
- de  output  1  high while both axes are in ACTIVE
- x  output  10  pixel column when de=1, else 0
- y  output  10  pixel row when de=1, else 0
- sof  output  1  one-cycle pulse on the first pixel of a frame
- seq_err  output  1  sticky: illegal counter sequence detected
- h_phase  output  2  horizontal FSM state
- v_phase  output  2  vertical FSM state
- rgb  output  12  test-pattern colour (4:4:4)

Behaviour:
- Reset, asynchronous and active-high:
  - both FSMs go to ACTIVE.
  - hsync=~HS_POL and vsync=~VS_POL.
  - de=0, x=0, y=0, sof=0, seq_err=0, rgb=0.
  - the previous-value registers prev_h and prev_v are set to H_TOTAL-1 and V_TOTAL-1, so the first h_val=0 is legal.
- All outputs are registered. Latency is 1 cycle: outputs at edge n+1 reflect h_val/v_val sampled at edge n. With cen=0, nothing updates, including sof.
- FSM states, common to both axes: ACTIVE=0, FP=1, SYNC=2, BP=3.
- Horizontal transitions:
  - ACTIVE→FP when h_val==H_ACTIVE.
  - FP→SYNC when h_val==H_ACTIVE+H_FP.
  - SYNC→BP when h_val==H_ACTIVE+H_FP+H_SYNC.
  - BP→ACTIVE when h_val==0.
  - h_val==0 forces ACTIVE from any state (resync).
- Vertical transitions: same scheme using v_val and the V_* parameters. Evaluated every enabled cycle, since v_val is stable within a line.
- Output decoding:
  - hsync is asserted only while h_phase==SYNC; vsync only while v_phase==SYNC.
  - de=1 iff both next-phases are ACTIVE.
  - x=h_val and y=v_val when de=1, otherwise 0.
- sof=1 for one cycle when h_val==0 and v_val==0 and the previous sample was not (0,0).
- Horizontal sequence check. Legal when:
  - h_val==prev_h+1, or
  - prev_h==H_TOTAL-1 and h_val==0.
- Vertical sequence check. Legal when:
  - v_val==prev_v, or
  - v_val==prev_v+1, or
  - prev_v==V_TOTAL-1 and v_val==0.
- On an illegal sequence:
  - seq_err is set and stays set until rst.
  - the FSM of the offending axis is re-derived directly from the value by range comparison (no walking through states).
- Range errors: h_val≥H_TOTAL or v_val≥V_TOTAL sets seq_err. The affected axis is treated as BP, so sync is deasserted and de=0.
- Widths: all comparisons are unsigned 10-bit, and prev+1 is computed in 11 bits so it does not wrap.

Optional Feature:
- Macro: VGA_TESTPAT_EN.
- Defined:
  - rgb is registered alongside de.
  - When de=1: eight vertical colour bars of width H_ACTIVE/8 (80). Bar index is x/80, giving in order: white, yellow, cyan, green, magenta, red, blue, black. Channel values are 4'hF or 4'h0.
  - When de=0: rgb=0.
- Undefined: rgb is tied to 12'h000 and no bar logic is synthesised.

Test Plan:
- Reset with rst=1, then release and drive a legal raster (h 0..823, v 0..600):
  - hsync goes low during h=656..751 (output one cycle later).
  - vsync goes low during v=490..491.
  - de is high for h<640 and v<480.
  - seq_err stays 0.
- Frame boundary, h 823→0 with v 600→0: sof pulses exactly once, one cycle later; x=0, y=0, de=1.
- Drive h_val 100→105 mid-line: seq_err=1 next cycle, h_phase=ACTIVE, x=105. seq_err stays 1 until rst.
- Drive h_val=900: seq_err=1, de=0, hsync deasserted.
- Hold cen=0 for 10 cycles mid-sync: all outputs frozen; on resume the sequence continues with no error.
- With VGA_TESTPAT_EN defined: x=0→rgb=FFF, x=85→FF0, x=479→F00, x=639→000; in blanking rgb=000.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA timing decoder: turns raw h/v counter values into registered syncs, de, coordinates and sof,
// with per-axis phase FSMs and a sticky sequence checker. Define VGA_TESTPAT_EN for colour-bar rgb.
`timescale 1ns/1ps
module vga_sync_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_TOTAL  = 824,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_TOTAL  = 601,
    parameter int unsigned HS_POL   = 0,
    parameter int unsigned VS_POL   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic [9:0]  h_val,
    input  logic [9:0]  v_val,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        sof,
    output logic        seq_err,
    output logic [1:0]  h_phase,
    output logic [1:0]  v_phase,
    output logic [11:0] rgb
);
    localparam int unsigned W = 10;

    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_FP     = 2'd1;
    localparam logic [1:0] ST_SYNC   = 2'd2;
    localparam logic [1:0] ST_BP     = 2'd3;

    localparam logic HS_ON = 1'(HS_POL);
    localparam logic VS_ON = 1'(VS_POL);

    localparam logic [W-1:0] H_FP_AT   = W'(H_ACTIVE);
    localparam logic [W-1:0] H_SYNC_AT = W'(H_ACTIVE + H_FP);
    localparam logic [W-1:0] H_BP_AT   = W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [W-1:0] H_LAST    = W'(H_TOTAL - 1);
    localparam logic [W-1:0] V_FP_AT   = W'(V_ACTIVE);
    localparam logic [W-1:0] V_SYNC_AT = W'(V_ACTIVE + V_FP);
    localparam logic [W-1:0] V_BP_AT   = W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [W-1:0] V_LAST    = W'(V_TOTAL - 1);

    logic [W-1:0] prev_h, prev_v;
    logic [1:0]   h_nxt, v_nxt;
    logic         h_rng, v_rng, h_legal, v_legal;
    logic         de_nxt, sof_nxt, err_nxt;
    logic [W:0]   h_inc, v_inc;

    // Out-of-range forces BP, a broken sequence re-derives from the value, otherwise walk edges.
    function automatic logic [1:0] phase_step(input logic [1:0] cur, input logic [W-1:0] val,
                                              input logic in_rng, input logic legal,
                                              input logic [W-1:0] fp_at, input logic [W-1:0] sync_at,
                                              input logic [W-1:0] bp_at);
        logic [1:0] nxt;
        nxt = cur;
        if (!in_rng) begin
            nxt = ST_BP;
        end else if (!legal) begin
            if (val < fp_at)        nxt = ST_ACTIVE;
            else if (val < sync_at) nxt = ST_FP;
            else if (val < bp_at)   nxt = ST_SYNC;
            else                    nxt = ST_BP;
        end else if (val == '0) begin
            nxt = ST_ACTIVE;
        end else begin
            case (cur)
                ST_ACTIVE: if (val == fp_at)   nxt = ST_FP;
                ST_FP:     if (val == sync_at) nxt = ST_SYNC;
                ST_SYNC:   if (val == bp_at)   nxt = ST_BP;
                default:   nxt = ST_BP;
            endcase
        end
        return nxt;
    endfunction

    always_comb begin
        h_inc   = {1'b0, prev_h} + (W+1)'(1);
        v_inc   = {1'b0, v_val} - (W+1)'(0) == {1'b0, prev_v} ? {1'b0, prev_v} : {1'b0, prev_v} + (W+1)'(1);
        h_rng   = h_val < W'(H_TOTAL);
        v_rng   = v_val < W'(V_TOTAL);
        h_legal = ({1'b0, h_val} == h_inc) || (prev_h == H_LAST && h_val == '0);
        v_legal = ({1'b0, v_val} == v_inc) || (prev_v == V_LAST && v_val == '0);
        h_nxt   = phase_step(h_phase, h_val, h_rng, h_legal, H_FP_AT, H_SYNC_AT, H_BP_AT);
        v_nxt   = phase_step(v_phase, v_val, v_rng, v_legal, V_FP_AT, V_SYNC_AT, V_BP_AT);
        de_nxt  = (h_nxt == ST_ACTIVE) && (v_nxt == ST_ACTIVE);
        sof_nxt = (h_val == '0) && (v_val == '0) && !(prev_h == '0 && prev_v == '0);
        err_nxt = seq_err | ~h_rng | ~v_rng | ~h_legal | ~v_legal;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_phase <= ST_ACTIVE;
            v_phase <= ST_ACTIVE;
            prev_h  <= H_LAST;
            prev_v  <= V_LAST;
            hsync   <= ~HS_ON;
            vsync   <= ~VS_ON;
            de      <= 1'b0;
            x       <= '0;
            y       <= '0;
            sof     <= 1'b0;
            seq_err <= 1'b0;
        end else if (cen) begin
            h_phase <= h_nxt;
            v_phase <= v_nxt;
            prev_h  <= h_val;
            prev_v  <= v_val;
            hsync   <= (h_nxt == ST_SYNC) ? HS_ON : ~HS_ON;
            vsync   <= (v_nxt == ST_SYNC) ? VS_ON : ~VS_ON;
            de      <= de_nxt;
            x       <= de_nxt ? h_val : '0;
            y       <= de_nxt ? v_val : '0;
            sof     <= sof_nxt;
            seq_err <= err_nxt;
        end
    end

`ifdef VGA_TESTPAT_EN
    localparam logic [W-1:0] BAR_W = W'(H_ACTIVE / 8);

    logic [2:0]  bar;
    logic [11:0] rgb_nxt;

    // Bars in order white, yellow, cyan, green, magenta, red, blue, black.
    always_comb begin
        bar     = 3'(h_val / BAR_W);
        rgb_nxt = 12'h000;
        if (de_nxt) begin
            case (bar)
                3'd0:    rgb_nxt = 12'hFFF;
                3'd1:    rgb_nxt = 12'hFF0;
                3'd2:    rgb_nxt = 12'h0FF;
                3'd3:    rgb_nxt = 12'h0F0;
                3'd4:    rgb_nxt = 12'hF0F;
                3'd5:    rgb_nxt = 12'hF00;
                3'd6:    rgb_nxt = 12'h00F;
                default: rgb_nxt = 12'h000;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      rgb <= 12'h000;
        else if (cen) rgb <= rgb_nxt;
    end
`else
    assign rgb = 12'h000;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed self-checking bench for vga_sync_gen (raster sweep, frame wrap, sequence/range errors,
// clock-enable freeze, and colour bars when VGA_TESTPAT_EN is defined).
`timescale 1ns/1ps
module tb_vga_sync_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic        cen;
    logic [9:0]  h_val, v_val;
    logic        hsync, vsync, de, sof, seq_err;
    logic [9:0]  x, y;
    logic [1:0]  h_phase, v_phase;
    logic [11:0] rgb;

    int errors = 0;
    int checks = 0;

    vga_sync_gen dut (
        .clk(clk), .rst(rst), .cen(cen), .h_val(h_val), .v_val(v_val),
        .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y), .sof(sof),
        .seq_err(seq_err), .h_phase(h_phase), .v_phase(v_phase), .rgb(rgb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply one enabled sample; outputs are checked 1 time unit after the capturing edge.
    task automatic cyc(input int h, input int v);
        @(negedge clk);
        cen   = 1'b1;
        h_val = 10'(h);
        v_val = 10'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cen = 1'b0;
        h_val = '0;
        v_val = '0;
        @(posedge clk);
        #1;
        check("rst_hsync", 32'(hsync), 32'd1);
        check("rst_vsync", 32'(vsync), 32'd1);
        check("rst_de", 32'(de), 32'd0);
        check("rst_x", 32'(x), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_sof", 32'(sof), 32'd0);
        check("rst_err", 32'(seq_err), 32'd0);
        check("rst_hph", 32'(h_phase), 32'd0);
        check("rst_vph", 32'(v_phase), 32'd0);
        check("rst_rgb", 32'(rgb), 32'h000);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int v;
        logic exp_de;
        logic [11:0] exp_rgb;
        rst = 1'b1; cen = 1'b0; h_val = '0; v_val = '0;

        // Raster sweep: h runs 0..823 while v climbs with it and parks at 600.
        do_reset();
        for (int i = 0; i < 824; i++) begin
            v = (i > 600) ? 600 : i;
            cyc(i, v);
            exp_de = (i < 480);
            check("sw_hsync", 32'(hsync), (i >= 656 && i <= 751) ? 32'd0 : 32'd1);
            check("sw_vsync", 32'(vsync), (v == 490 || v == 491) ? 32'd0 : 32'd1);
            check("sw_de", 32'(de), 32'(exp_de));
            check("sw_x", 32'(x), exp_de ? 32'(i) : 32'd0);
            check("sw_y", 32'(y), exp_de ? 32'(v) : 32'd0);
            check("sw_sof", 32'(sof), (i == 0) ? 32'd1 : 32'd0);
            check("sw_err", 32'(seq_err), 32'd0);
            check("sw_hph", 32'(h_phase), i < 640 ? 32'd0 : i < 656 ? 32'd1 : i < 752 ? 32'd2 : 32'd3);
            check("sw_vph", 32'(v_phase), v < 480 ? 32'd0 : v < 490 ? 32'd1 : v < 492 ? 32'd2 : 32'd3);
`ifdef VGA_TESTPAT_EN
            if (i == 0)   check("bar_x0", 32'(rgb), 32'hFFF);
            if (i == 85)  check("bar_x85", 32'(rgb), 32'hFF0);
            if (i == 479) check("bar_x479", 32'(rgb), 32'hF00);
`endif
            if (i == 700) check("sw_rgb_blank", 32'(rgb), 32'h000);
        end

        // Frame wrap (823,600) -> (0,0): single sof pulse, first pixel active.
        cyc(0, 0);
        check("wrap_sof", 32'(sof), 32'd1);
        check("wrap_de", 32'(de), 32'd1);
        check("wrap_x", 32'(x), 32'd0);
        check("wrap_y", 32'(y), 32'd0);
        check("wrap_err", 32'(seq_err), 32'd0);
        cyc(1, 1);
        check("wrap_sof_once", 32'(sof), 32'd0);

        // Skip 100 -> 105 mid-line.
        for (int i = 2; i <= 100; i++) cyc(i, 1);
        check("pre_skip_err", 32'(seq_err), 32'd0);
        cyc(105, 1);
        check("skip_err", 32'(seq_err), 32'd1);
        check("skip_hph", 32'(h_phase), 32'd0);
        check("skip_x", 32'(x), 32'd105);
        cyc(106, 1);
        check("skip_sticky", 32'(seq_err), 32'd1);
        check("skip_x106", 32'(x), 32'd106);

        // Out-of-range h.
        cyc(900, 1);
        check("rng_err", 32'(seq_err), 32'd1);
        check("rng_de", 32'(de), 32'd0);
        check("rng_hsync", 32'(hsync), 32'd1);
        check("rng_hph", 32'(h_phase), 32'd3);
        check("rng_x", 32'(x), 32'd0);

        // Clock-enable freeze in the middle of hsync.
        do_reset();
        for (int i = 0; i < 700; i++) begin
            cyc(i, 0);
            if (i == 639) begin
                check("ln_de639", 32'(de), 32'd1);
                check("ln_x639", 32'(x), 32'd639);
`ifdef VGA_TESTPAT_EN
                exp_rgb = 12'h000;
`else
                exp_rgb = 12'h000;
`endif
                check("ln_rgb639", 32'(rgb), 32'(exp_rgb));
            end
            if (i == 640) begin
                check("ln_de640", 32'(de), 32'd0);
                check("ln_rgb640", 32'(rgb), 32'h000);
            end
            if (i == 10) begin
`ifdef VGA_TESTPAT_EN
                exp_rgb = 12'hFFF;
`else
                exp_rgb = 12'h000;
`endif
                check("ln_rgb10", 32'(rgb), 32'(exp_rgb));
            end
        end
        check("pre_hold_hsync", 32'(hsync), 32'd0);
        check("pre_hold_hph", 32'(h_phase), 32'd2);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            cen = 1'b0;
            h_val = 10'd5;
            v_val = 10'd7;
            @(posedge clk);
            #1;
            check("hold_hsync", 32'(hsync), 32'd0);
            check("hold_hph", 32'(h_phase), 32'd2);
            check("hold_de", 32'(de), 32'd0);
            check("hold_sof", 32'(sof), 32'd0);
            check("hold_err", 32'(seq_err), 32'd0);
        end
        for (int i = 700; i <= 760; i++) begin
            cyc(i, 0);
            if (i == 751) check("res_hsync751", 32'(hsync), 32'd0);
            if (i == 752) check("res_hsync752", 32'(hsync), 32'd1);
            check("res_err", 32'(seq_err), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
